cache_arbiter: RTL

Round-robin arbiter and lookup sequencer that shares the single `Cache` search port between `NUM_REQ` requesters, such as fetch and load units. It accepts one request at a time, pulses `search_cache`, waits for `search_done`, and returns hit, data and tag to the winning requester with its ID. It also keeps saturating hit and miss statistics. A watchdog bounds the wait, so a stalled cache cannot hang the requesters.

---
 rtl/cache_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/cache_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache lookup arbiter.
package cache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_TAG_W  = 28;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward starting one past last_grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache search port between NUM_REQ requesters; one lookup in flight,
// bounded by a watchdog, with saturating hit/miss statistics.
module cache_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = cache_pkg::DEF_ADDR_W,
  parameter int DATA_W  = cache_pkg::DEF_DATA_W,
  parameter int TAG_W   = cache_pkg::DEF_TAG_W,
  parameter int TIMEOUT = 15,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_hit,
  output logic [DATA_W-1:0]         resp_data,
  output logic [TAG_W-1:0]          resp_tag,
  output logic                      resp_timeout,
  output logic                      search_cache,
  output logic [ADDR_W-1:0]         cache_address,
  input  logic                      search_done,
  input  logic                      hit,
  input  logic [DATA_W-1:0]         data,
  input  logic [TAG_W-1:0]          tag_out,
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count
);
  import cache_pkg::*;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    lat_id;
  logic [7:0]         timer;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Grant is only visible while idle so requesters never see a stale ready.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign resp_id   = lat_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= ID_W'(NUM_REQ - 1);
      lat_id        <= '0;
      cache_address <= '0;
      search_cache  <= 1'b0;
      timer         <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_timeout  <= 1'b0;
      resp_data     <= '0;
      resp_tag      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_id        <= grant_idx;
            cache_address <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            search_cache  <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          search_cache <= 1'b0;
          timer        <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (search_done) begin
            resp_hit      <= hit;
            resp_data     <= data;
            resp_tag      <= tag_out;
            resp_timeout  <= 1'b0;
            resp_valid    <= 1'b1;
            cache_address <= '0;
            state         <= RESP;
            if (hit) begin
              if (hit_count != CNT_MAX) hit_count <= hit_count + 16'd1;
            end else begin
              if (miss_count != CNT_MAX) miss_count <= miss_count + 16'd1;
            end
          end else if (timer == TIMER_LAST) begin
            resp_hit      <= 1'b0;
            resp_data     <= '0;
            resp_tag      <= '0;
            resp_timeout  <= 1'b1;
            resp_valid    <= 1'b1;
            cache_address <= '0;
            state         <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= lat_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
